// File: rtl/digit_entry_editor_pkg.sv
// Shared types and constants for the 4-digit entry editor.
// Digit codes, packed word layout, FSM encoding and digit stepping.
package digit_entry_pkg;

  localparam int DIGIT_W    = 5;
  localparam int NUM_DIGITS = 4;
  localparam int WORD_W     = DIGIT_W * NUM_DIGITS;
  localparam int CURSOR_W   = 2;
  localparam int NUM_BTN    = 5;

  localparam logic [DIGIT_W-1:0] BLANK_CODE = 5'b10001;

  // Button bit positions, highest index = highest priority
  localparam int B_ENT = 4;
  localparam int B_UP  = 3;
  localparam int B_DN  = 2;
  localparam int B_LF  = 1;
  localparam int B_RT  = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  typedef logic [DIGIT_W-1:0]  digit_t;
  typedef logic [WORD_W-1:0]   word_t;
  typedef logic [CURSOR_W-1:0] cursor_t;

  function automatic digit_t digit_step(
    input digit_t d,
    input logic   dn,
    input digit_t max
  );
    digit_t r;
    if (dn) r = (d == '0 || d > max) ? max : d - 1'b1;
    else    r = (d >= max) ? '0 : d + 1'b1;
    return r;
  endfunction

  // Cursor 0 is the leftmost digit, i.e. the most significant field
  function automatic logic [4:0] digit_lsb(input cursor_t c);
    return 5'((NUM_DIGITS - 1 - int'(c)) * DIGIT_W);
  endfunction

endpackage

// File: rtl/digit_entry_editor_if.sv
// Button inputs and display/commit outputs of the digit entry editor.
// master drives buttons, slave is the editor.
interface digit_entry_editor_if;
  import digit_entry_pkg::*;

  logic    btn_left;
  logic    btn_right;
  logic    btn_up;
  logic    btn_down;
  logic    btn_enter;
  word_t   disps;
  cursor_t blink;
  logic    edit_active;
  logic    commit_valid;
  word_t   value;

  modport master (
    output btn_left, btn_right, btn_up, btn_down, btn_enter,
    input  disps, blink, edit_active, commit_valid, value
  );

  modport slave (
    input  btn_left, btn_right, btn_up, btn_down, btn_enter,
    output disps, blink, edit_active, commit_valid, value
  );
endinterface

// File: rtl/digit_entry_editor_btn_conditioner.sv
// Raw button -> 2-FF sync -> debounce counter -> rising-edge pulse.
// Level changes after DEBOUNCE_CYCLES consecutive differing samples.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;

  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = sync_q[1];
      else cnt_d = cnt_q + 1'b1;
    end
    pulse_d = level_d & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/digit_entry_editor.sv
// Button-driven editor for a 4-digit 7-segment display value.
// Optional auto-repeat of up/down: DIGIT_ENTRY_AUTO_REPEAT_EN.
module digit_entry_editor
  import digit_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int MAX_DIGIT       = 9,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input logic                 clk,
  input logic                 reset,
  digit_entry_editor_if.slave bus
);

  localparam digit_t MAXD = digit_t'(MAX_DIGIT);

  if (MAX_DIGIT < 1 || MAX_DIGIT > 15 ||
      MAX_DIGIT >= int'(BLANK_CODE) ||
      REPEAT_PERIOD < 1 || REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_cfg
    $error("digit_entry_editor: illegal parameter set");
  end

  logic [NUM_BTN-1:0] raw, lvl, pls, act;

  assign raw = {bus.btn_enter, bus.btn_up, bus.btn_down,
                bus.btn_left, bus.btn_right};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond (
      .clk    (clk),
      .reset  (reset),
      .btn_raw(raw[i]),
      .level  (lvl[i]),
      .pulse  (pls[i])
    );
  end

  assign act = pls & lvl;

  state_e  state_q, state_d;
  word_t   working_q, working_d;
  word_t   value_q, value_d;
  word_t   disps_q, disps_d;
  cursor_t cursor_q, cursor_d;
  cursor_t blink_q, blink_d;

  logic syn_up, syn_dn;

`ifdef DIGIT_ENTRY_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);

  logic          rpt_on_q, rpt_on_d;
  logic          rpt_dn_q, rpt_dn_d;
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          hold_ok;

  // Repeat runs only while the pressed direction is the sole held button
  always_comb begin
    rpt_on_d  = rpt_on_q;
    rpt_dn_d  = rpt_dn_q;
    rpt_cnt_d = rpt_cnt_q;
    syn_up    = 1'b0;
    syn_dn    = 1'b0;
    hold_ok   = rpt_dn_q ? (lvl == NUM_BTN'(1 << B_DN))
                         : (lvl == NUM_BTN'(1 << B_UP));
    if (state_q != EDIT) begin
      rpt_on_d  = 1'b0;
      rpt_cnt_d = '0;
    end else if (|act) begin
      rpt_on_d  = (act == NUM_BTN'(1 << B_UP)) ||
                  (act == NUM_BTN'(1 << B_DN));
      rpt_dn_d  = act[B_DN];
      rpt_cnt_d = '0;
    end else if (rpt_on_q && hold_ok) begin
      if (rpt_cnt_q == RW'(REPEAT_DELAY - 1)) begin
        syn_up    = ~rpt_dn_q;
        syn_dn    = rpt_dn_q;
        rpt_cnt_d = RW'(REPEAT_DELAY - REPEAT_PERIOD);
      end else begin
        rpt_cnt_d = rpt_cnt_q + 1'b1;
      end
    end else begin
      rpt_on_d  = 1'b0;
      rpt_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_on_q  <= 1'b0;
      rpt_dn_q  <= 1'b0;
      rpt_cnt_q <= '0;
    end else begin
      rpt_on_q  <= rpt_on_d;
      rpt_dn_q  <= rpt_dn_d;
      rpt_cnt_q <= rpt_cnt_d;
    end
  end
`else
  assign syn_up = 1'b0;
  assign syn_dn = 1'b0;
`endif

  logic       do_up, do_dn;
  logic       sel_ent, sel_up, sel_dn, sel_lf, sel_rt;
  logic [4:0] cur_lsb;
  digit_t     cur_digit;

  assign do_up   = act[B_UP] | syn_up;
  assign do_dn   = act[B_DN] | syn_dn;
  assign sel_ent = act[B_ENT];
  assign sel_up  = do_up & ~sel_ent;
  assign sel_dn  = do_dn & ~sel_ent & ~do_up;
  assign sel_lf  = act[B_LF] & ~sel_ent & ~do_up & ~do_dn;
  assign sel_rt  = act[B_RT] & ~sel_ent & ~do_up & ~do_dn & ~act[B_LF];

  assign cur_lsb   = digit_lsb(cursor_q);
  assign cur_digit = working_q[cur_lsb +: DIGIT_W];

  always_comb begin
    state_d   = state_q;
    working_d = working_q;
    cursor_d  = cursor_q;
    value_d   = value_q;
    unique case (state_q)
      IDLE: begin
        if (sel_ent) begin
          state_d   = EDIT;
          working_d = value_q;
          cursor_d  = '0;
        end
      end
      EDIT: begin
        unique case (1'b1)
          sel_ent: state_d = COMMIT;
          sel_up:
            working_d[cur_lsb +: DIGIT_W] = digit_step(cur_digit, 1'b0, MAXD);
          sel_dn:
            working_d[cur_lsb +: DIGIT_W] = digit_step(cur_digit, 1'b1, MAXD);
          sel_lf:  cursor_d = cursor_q - 1'b1;
          sel_rt:  cursor_d = cursor_q + 1'b1;
          default: ;
        endcase
      end
      COMMIT: begin
        value_d = working_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    disps_d = (state_d == IDLE) ? value_d : working_d;
    blink_d = (state_d == EDIT) ? cursor_d : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      working_q <= '0;
      cursor_q  <= '0;
      value_q   <= '0;
      disps_q   <= '0;
      blink_q   <= '0;
    end else begin
      state_q   <= state_d;
      working_q <= working_d;
      cursor_q  <= cursor_d;
      value_q   <= value_d;
      disps_q   <= disps_d;
      blink_q   <= blink_d;
    end
  end

  assign bus.disps        = disps_q;
  assign bus.blink        = blink_q;
  assign bus.edit_active  = (state_q == EDIT);
  assign bus.commit_valid = (state_q == COMMIT);
  assign bus.value        = value_q;

endmodule
